// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: HI/LO multiply/divide unit controller for the E stage.
// Multiplies and MTHI/MTLO complete in one cycle. Divides run a 32-cycle
// restoring divider that stalls the pipeline.
// Build option: DIV_ZERO_FAST_EN sends divide-by-zero from accept straight
// to DONE with result {rs, 32'hFFFF_FFFF}.
module hilo_mdu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        e_valid,
   input  logic [2:0]  e_op,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic        e_flush,
   input  logic [63:0] hilo_cur,
   output logic        stall_o,
   output logic        res_valid,
   output logic [63:0] res_hilo
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned HLW  = 2 * XLEN;
   localparam int unsigned CW   = 5;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef DIV_ZERO_FAST_EN
   localparam bit FastZero = 1'b1;
`else
   localparam bit FastZero = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [XLEN-1:0]   rem_q;
   logic [XLEN-1:0]   quo_q;
   logic [XLEN-1:0]   dvs_q;
   logic              neg_quo_q;
   logic              neg_rem_q;
   logic              res_valid_q;
   logic [HLW-1:0]    res_hilo_q;

   logic              accept;
   logic              div_accept;
   logic              rs_neg;
   logic              rt_neg;
   logic [XLEN-1:0]   rs_mag;
   logic [XLEN-1:0]   rt_mag;
   logic [HLW-1:0]    prod_s;
   logic [HLW-1:0]    prod_u;
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   diff;
   logic [XLEN-1:0]   rem_nx;
   logic [XLEN-1:0]   quo_nx;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   quo_fix;

   // Accept decode, operand conditioning and products
   always_comb begin
      accept     = (state_q == IDLE) && e_valid && !e_flush;
      div_accept = accept && ((e_op == OP_DIV) || (e_op == OP_DIVU));
      rs_neg     = (e_op == OP_DIV) && e_rs[XLEN-1];
      rt_neg     = (e_op == OP_DIV) && e_rt[XLEN-1];
      rs_mag     = rs_neg ? (~e_rs + 32'd1) : e_rs;
      rt_mag     = rt_neg ? (~e_rt + 32'd1) : e_rt;
      prod_s     = {{XLEN{e_rs[XLEN-1]}}, e_rs} * {{XLEN{e_rt[XLEN-1]}}, e_rt};
      prod_u     = {32'd0, e_rs} * {32'd0, e_rt};
   end

   // One restoring-division step plus final sign fix-up
   always_comb begin
      rem_sh = {rem_q, quo_q[XLEN-1]};
      diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
      if (!diff[XLEN+1]) begin
         rem_nx = diff[XLEN-1:0];
         quo_nx = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_nx = rem_sh[XLEN-1:0];
         quo_nx = {quo_q[XLEN-2:0], 1'b0};
      end
      quo_fix = neg_quo_q ? (~quo_nx + 32'd1) : quo_nx;
      rem_fix = neg_rem_q ? (~rem_nx + 32'd1) : rem_nx;
   end

   // Stall covers the divide accept cycle and every unflushed DIV_RUN cycle
   always_comb begin
      stall_o   = rst && (div_accept || ((state_q == DIV_RUN) && !e_flush));
      res_valid = res_valid_q && !((state_q == DONE) && e_flush);
      res_hilo  = res_hilo_q;
   end

   // Control FSM, divider datapath and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_hilo_q  <= '0;
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  case (e_op)
                     OP_MULT: begin
                        res_hilo_q  <= prod_s;
                        res_valid_q <= 1'b1;
                     end
                     OP_MULTU: begin
                        res_hilo_q  <= prod_u;
                        res_valid_q <= 1'b1;
                     end
                     OP_MTHI: begin
                        res_hilo_q  <= {e_rs, hilo_cur[XLEN-1:0]};
                        res_valid_q <= 1'b1;
                     end
                     OP_MTLO: begin
                        res_hilo_q  <= {hilo_cur[HLW-1:XLEN], e_rs};
                        res_valid_q <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (FastZero && (e_rt == 32'd0)) begin
                           res_hilo_q  <= {e_rs, 32'hFFFF_FFFF};
                           res_valid_q <= 1'b1;
                           state_q     <= DONE;
                        end else begin
                           rem_q     <= '0;
                           quo_q     <= rs_mag;
                           dvs_q     <= rt_mag;
                           neg_quo_q <= rs_neg ^ rt_neg;
                           neg_rem_q <= rs_neg;
                           cnt_q     <= '0;
                           state_q   <= DIV_RUN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            DIV_RUN: begin
               if (e_flush) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == 5'd31) begin
                  res_hilo_q  <= {rem_fix, quo_fix};
                  res_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= DONE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
